otter_mem_arbiter: RTL and testbench



---
 rtl/otter_arb_pkg.sv | 22 ++
 rtl/otter_rr_pick.sv | 26 ++
 rtl/otter_mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_otter_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_arb_pkg.sv
// otter_arb_pkg
// Shared types and constants for the OTTER memory port-2 arbiter.
//   arb_state_t : arbiter FSM states (IDLE, RD_WAIT)
//   REQ_CPU/REQ_DMA : requester IDs, also used as bit positions in req/gnt vectors
//   mem_size_t  : MEM_SIZE codes as carried in ir[13:12]
package otter_arb_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } arb_state_t;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mem_size_t;

endpackage

// File: rtl/otter_rr_pick.sv
// otter_rr_pick
// Two-way round-robin picker.
//   req[1:0] : request vector, bit index = requester ID
//   last     : ID of the most recently granted requester
//   en       : arbitration allowed this cycle
//   gnt[1:0] : one-hot grant (all zero when en=0 or no request)
//   winner   : ID of the granted requester (REQ_CPU when nobody is granted)
module otter_rr_pick
  import otter_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       winner
);

  // A requester wins if it is alone, or if the other one was served last.
  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    localparam logic ID = 1'(gi);
    assign gnt[gi] = en & req[gi] & (~req[1-gi] | (last != ID));
  end

  assign winner = gnt[REQ_DMA] ? REQ_DMA : REQ_CPU;

endmodule

// File: rtl/otter_mem_arbiter.sv
// otter_mem_arbiter
// Arbitrates the OTTER memory data port (port 2) between the CPU load/store
// path and a DMA/debug master. Round-robin on contention, one read
// outstanding at a time, writes complete in their grant cycle.
//
// Ports:
//   clk, RST                 : clock, synchronous active-high reset
//   cpu_* / dma_* (inputs)   : req, we, addr, din, size, sign per requester
//   cpu_gnt / dma_gnt        : command accepted this cycle (combinational)
//   cpu_rvalid / dma_rvalid  : read data valid pulse for the owning requester
//   rdata                    : mem_dout2 while an rvalid is high, else 0
//   mem_rden2, mem_we2, mem_addr2, mem_din2, mem_size, mem_sign : to Memory
//   mem_dout2                : from Memory
//   cpu_stall_cnt, dma_stall_cnt : only when ARB_PERF_EN is defined;
//                              saturating count of cycles with req=1, gnt=0
//
// Parameters: READ_LAT (1..3) grant-to-data latency, AW address width,
// DW data width.
module otter_mem_arbiter
  import otter_arb_pkg::*;
#(
  parameter int READ_LAT = 1,
  parameter int AW       = 32,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic [1:0]    cpu_size,
  input  logic          cpu_sign,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_din,
  input  logic [1:0]    dma_size,
  input  logic          dma_sign,
  output logic          dma_gnt,
  output logic          dma_rvalid,
  output logic [DW-1:0] rdata,
  output logic          mem_rden2,
  output logic          mem_we2,
  output logic [AW-1:0] mem_addr2,
  output logic [DW-1:0] mem_din2,
  output logic [1:0]    mem_size,
  output logic          mem_sign,
  input  logic [DW-1:0] mem_dout2
`ifdef ARB_PERF_EN
  ,
  output logic [31:0]   cpu_stall_cnt,
  output logic [31:0]   dma_stall_cnt
`endif
);

  localparam logic [1:0] RD_CNT_INIT = 2'(READ_LAT - 1);

  arb_state_t state_reg;
  logic [1:0] rd_cnt_reg;
  logic       owner_reg;
  logic       last_gnt_reg;

  logic       rd_done;
  logic       arb_en;
  logic [1:0] req_vec;
  logic [1:0] gnt_vec;
  logic       winner;
  logic       any_gnt;
  logic       win_we;

  // The completion cycle of a read is also a free arbitration slot.
  assign rd_done = (state_reg == RD_WAIT) && (rd_cnt_reg == 2'd0);
  assign arb_en  = (state_reg == IDLE) || rd_done;

  assign req_vec[REQ_CPU] = cpu_req;
  assign req_vec[REQ_DMA] = dma_req;

  otter_rr_pick u_pick (
    .req    (req_vec),
    .last   (last_gnt_reg),
    .en     (arb_en),
    .gnt    (gnt_vec),
    .winner (winner)
  );

  assign cpu_gnt = gnt_vec[REQ_CPU];
  assign dma_gnt = gnt_vec[REQ_DMA];
  assign any_gnt = |gnt_vec;
  assign win_we  = (winner == REQ_DMA) ? dma_we : cpu_we;

  assign cpu_rvalid = rd_done && (owner_reg == REQ_CPU);
  assign dma_rvalid = rd_done && (owner_reg == REQ_DMA);
  assign rdata      = rd_done ? mem_dout2 : '0;

  // Memory command mux: driven only in a grant cycle, zero otherwise.
  always_comb begin
    mem_rden2 = 1'b0;
    mem_we2   = 1'b0;
    mem_addr2 = '0;
    mem_din2  = '0;
    mem_size  = 2'd0;
    mem_sign  = 1'b0;
    if (any_gnt) begin
      mem_we2   = win_we;
      mem_rden2 = !win_we;
      if (winner == REQ_DMA) begin
        mem_addr2 = dma_addr;
        mem_din2  = dma_din;
        mem_size  = dma_size;
        mem_sign  = dma_sign;
      end else begin
        mem_addr2 = cpu_addr;
        mem_din2  = cpu_din;
        mem_size  = cpu_size;
        mem_sign  = cpu_sign;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state_reg    <= IDLE;
      rd_cnt_reg   <= 2'd0;
      owner_reg    <= REQ_CPU;
      last_gnt_reg <= REQ_DMA;
    end else begin
      if (any_gnt) begin
        last_gnt_reg <= winner;
      end
      if (arb_en) begin
        // Either idle or finishing a read: a new read re-arms the wait,
        // anything else (write or no grant) leaves the bus idle.
        if (any_gnt && !win_we) begin
          state_reg  <= RD_WAIT;
          rd_cnt_reg <= RD_CNT_INIT;
          owner_reg  <= winner;
        end else begin
          state_reg  <= IDLE;
          rd_cnt_reg <= 2'd0;
        end
      end else begin
        rd_cnt_reg <= rd_cnt_reg - 2'd1;
      end
    end
  end

`ifdef ARB_PERF_EN
  always_ff @(posedge clk) begin
    if (RST) begin
      cpu_stall_cnt <= '0;
      dma_stall_cnt <= '0;
    end else begin
      if (cpu_req && !cpu_gnt && (cpu_stall_cnt != 32'hFFFF_FFFF)) begin
        cpu_stall_cnt <= cpu_stall_cnt + 32'd1;
      end
      if (dma_req && !dma_gnt && (dma_stall_cnt != 32'hFFFF_FFFF)) begin
        dma_stall_cnt <= dma_stall_cnt + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_otter_mem_arbiter.sv
// tb_otter_mem_arbiter
// Directed bench for otter_mem_arbiter. Three instances share all requester
// inputs and differ only in READ_LAT (1, 2, 3); each has its own small
// memory model. Each step checks the instance whose latency the step needs.
// Define ARB_PERF_EN to also check the stall counters.
module tb_otter_mem_arbiter;
  import otter_arb_pkg::*;

  logic        clk = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, cpu_sign;
  logic [31:0] cpu_addr, cpu_din;
  logic [1:0]  cpu_size;
  logic        dma_req, dma_we, dma_sign;
  logic [31:0] dma_addr, dma_din;
  logic [1:0]  dma_size;

  logic        cpu_gnt [3];
  logic        cpu_rvalid [3];
  logic        dma_gnt [3];
  logic        dma_rvalid [3];
  logic [31:0] rdata [3];
  logic        mem_rden2 [3];
  logic        mem_we2 [3];
  logic [31:0] mem_addr2 [3];
  logic [31:0] mem_din2 [3];
  logic [1:0]  mem_size [3];
  logic        mem_sign [3];
  logic [31:0] mem_dout2 [3];
`ifdef ARB_PERF_EN
  logic [31:0] cpu_stall_cnt [3];
  logic [31:0] dma_stall_cnt [3];
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic [31:0] mem [64];
    logic [31:0] rd_addr = 32'h0;

    otter_mem_arbiter #(.READ_LAT(gi + 1), .AW(32), .DW(32)) u_dut (
      .clk        (clk),
      .RST        (RST),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_din    (cpu_din),
      .cpu_size   (cpu_size),
      .cpu_sign   (cpu_sign),
      .cpu_gnt    (cpu_gnt[gi]),
      .cpu_rvalid (cpu_rvalid[gi]),
      .dma_req    (dma_req),
      .dma_we     (dma_we),
      .dma_addr   (dma_addr),
      .dma_din    (dma_din),
      .dma_size   (dma_size),
      .dma_sign   (dma_sign),
      .dma_gnt    (dma_gnt[gi]),
      .dma_rvalid (dma_rvalid[gi]),
      .rdata      (rdata[gi]),
      .mem_rden2  (mem_rden2[gi]),
      .mem_we2    (mem_we2[gi]),
      .mem_addr2  (mem_addr2[gi]),
      .mem_din2   (mem_din2[gi]),
      .mem_size   (mem_size[gi]),
      .mem_sign   (mem_sign[gi]),
      .mem_dout2  (mem_dout2[gi])
`ifdef ARB_PERF_EN
      ,
      .cpu_stall_cnt (cpu_stall_cnt[gi]),
      .dma_stall_cnt (dma_stall_cnt[gi])
`endif
    );

    // Memory model: word-addressed RAM plus a fixed word at 0x1000.
    // Read data follows the address latched on the last read command, so it
    // is stable from the cycle after the grant until the next read.
    assign mem_dout2[gi] = (rd_addr == 32'h0000_1000) ? 32'hDEAD_BEEF : mem[rd_addr[7:2]];

    always @(posedge clk) begin
      if (mem_we2[gi]) mem[mem_addr2[gi][7:2]] <= mem_din2[gi];
      if (mem_rden2[gi]) rd_addr <= mem_addr2[gi];
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after inputs change.
  task automatic settle();
    #2;
  endtask

  task automatic clear_reqs();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_size = WORD; cpu_sign = 1'b0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_din = '0; dma_size = WORD; dma_sign = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    settle();
    // Reset state, idle requesters.
    check("rst_cpu_gnt",   cpu_gnt[0],    0);
    check("rst_rvalid",    {cpu_rvalid[0], dma_rvalid[0]}, 0);
    check("rst_mem_cmd",   {mem_rden2[0], mem_we2[0]}, 0);
    check("rst_mem_addr",  mem_addr2[0],  0);
    check("rst_rdata",     rdata[0],      0);
    RST = 1'b0;
    nxt();

    // 1: CPU read 0x1000 alone, READ_LAT=1.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000; cpu_size = WORD; cpu_sign = 1'b1;
    settle();
    check("t1_cpu_gnt",    cpu_gnt[0],    1);
    check("t1_rden",       mem_rden2[0],  1);
    check("t1_we",         mem_we2[0],    0);
    check("t1_addr",       mem_addr2[0],  32'h0000_1000);
    check("t1_size",       mem_size[0],   2'd2);
    check("t1_sign",       mem_sign[0],   1);
    check("t1_no_rvalid",  cpu_rvalid[0], 0);
    nxt();
    cpu_req = 1'b0;
    settle();
    check("t1_cpu_rvalid", cpu_rvalid[0], 1);
    check("t1_rdata",      rdata[0],      32'hDEAD_BEEF);
    check("t1_dma_rvalid", dma_rvalid[0], 0);
    check("t1_no_gnt",     cpu_gnt[0],    0);
    nxt();
    settle();
    check("t1_rvalid_pulse", cpu_rvalid[0], 0);
    check("t1_rdata_zero",   rdata[0],      0);

    // 2: both write in the first cycle after reset.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10; cpu_din = 32'h11;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h20; dma_din = 32'h22;
    settle();
    check("t2_c0_cpu_gnt", cpu_gnt[0],   1);
    check("t2_c0_dma_gnt", dma_gnt[0],   0);
    check("t2_c0_we",      mem_we2[0],   1);
    check("t2_c0_rden",    mem_rden2[0], 0);
    check("t2_c0_addr",    mem_addr2[0], 32'h10);
    check("t2_c0_din",     mem_din2[0],  32'h11);
    nxt();
    cpu_req = 1'b0;
    settle();
    check("t2_c1_dma_gnt", dma_gnt[0],   1);
    check("t2_c1_cpu_gnt", cpu_gnt[0],   0);
    check("t2_c1_we",      mem_we2[0],   1);
    check("t2_c1_addr",    mem_addr2[0], 32'h20);
    check("t2_c1_din",     mem_din2[0],  32'h22);
    nxt();
    dma_req = 1'b0;
    settle();
    check("t2_c2_idle_we", mem_we2[0],   0);

    // 3: both hold reads, READ_LAT=2 (instance 1). Memory holds 0x11/0x22.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    settle();
    check("t3_c0_gnt",     {cpu_gnt[1], dma_gnt[1]}, 2'b10);
    check("t3_c0_addr",    mem_addr2[1], 32'h10);
    nxt();
    settle();
    check("t3_c1_gnt",     {cpu_gnt[1], dma_gnt[1]}, 2'b00);
    check("t3_c1_rvalid",  {cpu_rvalid[1], dma_rvalid[1]}, 2'b00);
    check("t3_c1_rden",    mem_rden2[1], 0);
    nxt();
    settle();
    check("t3_c2_rvalid",  {cpu_rvalid[1], dma_rvalid[1]}, 2'b10);
    check("t3_c2_rdata",   rdata[1],     32'h11);
    check("t3_c2_gnt",     {cpu_gnt[1], dma_gnt[1]}, 2'b01);
    check("t3_c2_addr",    mem_addr2[1], 32'h20);
    nxt();
    settle();
    check("t3_c3_gnt",     {cpu_gnt[1], dma_gnt[1]}, 2'b00);
    nxt();
    settle();
    check("t3_c4_rvalid",  {cpu_rvalid[1], dma_rvalid[1]}, 2'b01);
    check("t3_c4_rdata",   rdata[1],     32'h22);
    check("t3_c4_gnt",     {cpu_gnt[1], dma_gnt[1]}, 2'b10);
    nxt();
    clear_reqs();
    settle();
    check("t3_c5_quiet",   {cpu_rvalid[1], dma_rvalid[1], cpu_gnt[1], dma_gnt[1]}, 4'b0000);
    nxt();
    settle();
    check("t3_c6_rvalid",  {cpu_rvalid[1], dma_rvalid[1]}, 2'b10);
    check("t3_c6_rdata",   rdata[1],     32'h11);

    // 4: CPU read with READ_LAT=3 (instance 2); DMA write waits for completion.
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_1000;
    settle();
    check("t4_c0_cpu_gnt", cpu_gnt[2], 1);
    nxt();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h30; dma_din = 32'h33;
    settle();
    check("t4_c1_dma_wait", dma_gnt[2], 0);
    check("t4_c1_we",       mem_we2[2], 0);
    nxt();
    settle();
    check("t4_c2_dma_wait", dma_gnt[2], 0);
    nxt();
    settle();
    check("t4_c3_rvalid",   cpu_rvalid[2], 1);
    check("t4_c3_rdata",    rdata[2],      32'hDEAD_BEEF);
    check("t4_c3_dma_gnt",  dma_gnt[2],    1);
    check("t4_c3_we",       mem_we2[2],    1);
    check("t4_c3_addr",     mem_addr2[2],  32'h30);
    nxt();
    dma_req = 1'b0;
    settle();
    check("t4_c4_idle",     {cpu_rvalid[2], dma_gnt[2], mem_we2[2]}, 3'b000);
`ifdef ARB_PERF_EN
    check("t4_dma_stall",   dma_stall_cnt[2], 32'd2);
    check("t4_cpu_stall",   cpu_stall_cnt[2], 32'd0);
`endif

    // 5: reset during a DMA read, READ_LAT=2 (instance 1).
    do_reset();
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    settle();
    check("t5_c0_dma_gnt", dma_gnt[1], 1);
    nxt();
    dma_req = 1'b0;
    RST = 1'b1;
    nxt();
    RST = 1'b0;
    settle();
    check("t5_no_rvalid",  {cpu_rvalid[1], dma_rvalid[1]}, 2'b00);
    check("t5_rdata_zero", rdata[1],     0);
    check("t5_mem_quiet",  {mem_rden2[1], mem_we2[1]}, 2'b00);
    nxt();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h10;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h20;
    settle();
    check("t5_tie_cpu",    {cpu_gnt[1], dma_gnt[1]}, 2'b10);

    // 6: CPU write then DMA read of 0x40, READ_LAT=1 (instance 0).
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_din = 32'hA5A5_0001;
    settle();
    check("t6_c0_cpu_gnt", cpu_gnt[0], 1);
    check("t6_c0_din",     mem_din2[0], 32'hA5A5_0001);
    nxt();
    cpu_req = 1'b0;
    dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h40;
    settle();
    check("t6_c1_dma_gnt", dma_gnt[0],   1);
    check("t6_c1_rden",    mem_rden2[0], 1);
    nxt();
    dma_req = 1'b0;
    settle();
    check("t6_c2_rvalid",  {cpu_rvalid[0], dma_rvalid[0]}, 2'b01);
    check("t6_c2_rdata",   rdata[0],     32'hA5A5_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
